// File: rtl/countdown_timer_main_pkg.sv
// Shared definitions for the countdown timer: state encodings, time units and
// small arithmetic helpers used by the datapath and LED decode.
package countdown_timer_main_pkg;

  localparam int TIME_W     = 19;
  localparam int CS_PER_SEC = 100;
  localparam int CS_PER_MIN = 6000;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSE   = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  typedef logic [TIME_W-1:0] time_t;

  // Sum is formed one bit wider so an overflow past max_val is caught before truncation.
  function automatic time_t sat_add(input time_t base, input time_t inc, input time_t max_val);
    logic [TIME_W:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    if (sum > {1'b0, max_val}) return max_val;
    return sum[TIME_W-1:0];
  endfunction

  function automatic logic [9:0] spot_led(input time_t t);
    time_t      secs;
    logic [3:0] digit;
    secs  = t / time_t'(CS_PER_SEC);
    digit = 4'(secs % time_t'(10));
    return 10'd1 << digit;
  endfunction

endpackage

// File: rtl/countdown_timer_main_key_edge_detect.sv
// Active-low pushbutton conditioner: two-flop synchroniser followed by a
// registered falling-edge detector giving one press pulse per key push.
module key_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  logic sync1, sync2, sync3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      sync3 <= sync2;
      press <= sync3 & ~sync2;
    end
  end

endmodule

// File: rtl/countdown_timer_main.sv
// Countdown timer: MM:SS preset from keys, centisecond countdown, pause/resume,
// expiry flag with blinking LEDs. time_left is in centiseconds.
module countdown_timer_main
  import countdown_timer_main_pkg::*;
#(
  parameter int TICK_DIV = 500000,
  parameter int MAX_TIME = 359999,
  parameter int BLINK_CS = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key3,
  input  logic              key2,
  input  logic              key1,
  input  logic              key0,
  output logic [TIME_W-1:0] time_left,
  output logic              expired,
  output logic [9:0]        led
);

  localparam int    PS_W  = $clog2(TICK_DIV + 1);
  localparam int    BC_W  = $clog2(BLINK_CS + 1);
  localparam time_t MAX_T = time_t'(MAX_TIME);

  logic p0, p1, p2, p3;
  logic go0, go1, go2, go3, any_key, tick;

  logic [1:0]      state, state_nx;
  time_t           preset, preset_nx, time_nx;
  logic [PS_W-1:0] prescaler, prescaler_nx;
  logic [BC_W-1:0] blink_cnt, blink_cnt_nx;
  logic            blink, blink_nx;
  logic            expired_nx;
  logic [9:0]      led_nx;

  key_edge_detect u_key0 (.clk(clk), .rst(rst), .key_n(key0), .press(p0));
  key_edge_detect u_key1 (.clk(clk), .rst(rst), .key_n(key1), .press(p1));
  key_edge_detect u_key2 (.clk(clk), .rst(rst), .key_n(key2), .press(p2));
  key_edge_detect u_key3 (.clk(clk), .rst(rst), .key_n(key3), .press(p3));

  // Only the highest-priority pulse of a cycle is acted on.
  assign go0     = p0;
  assign go3     = p3 & ~p0;
  assign go2     = p2 & ~p0 & ~p3;
  assign go1     = p1 & ~p0 & ~p3 & ~p2;
  assign any_key = p0 | p1 | p2 | p3;

  assign tick = ((state == ST_RUN) || (state == ST_EXPIRED)) &&
                (prescaler == PS_W'(TICK_DIV - 1));

  always_comb begin
    state_nx  = state;
    time_nx   = time_left;
    preset_nx = preset;
    case (state)
      ST_IDLE: begin
        if (go0) time_nx = '0;
        else if (go3) begin
          if (time_left != '0) begin
            preset_nx = time_left;
            state_nx  = ST_RUN;
          end
        end
        else if (go2) time_nx = sat_add(time_left, time_t'(CS_PER_MIN), MAX_T);
        else if (go1) time_nx = sat_add(time_left, time_t'(CS_PER_SEC), MAX_T);
      end
      ST_RUN: begin
        if (go0) begin
          state_nx = ST_IDLE;
          time_nx  = preset;
        end else begin
          if (go3) state_nx = ST_PAUSE;
          // Expiry on the same tick as a pause request overrides the pause.
          if (tick && (time_left != '0)) begin
            time_nx = time_left - time_t'(1);
            if (time_left == time_t'(1)) state_nx = ST_EXPIRED;
          end
        end
      end
      ST_PAUSE: begin
        if (go0) begin
          state_nx = ST_IDLE;
          time_nx  = preset;
        end else if (go3) state_nx = ST_RUN;
      end
      default: begin
        time_nx = '0;
        if (any_key) begin
          state_nx = ST_IDLE;
          time_nx  = preset;
        end
      end
    endcase
  end

  always_comb begin
    prescaler_nx = prescaler;
    if ((state_nx == ST_IDLE) || ((state == ST_IDLE) && (state_nx == ST_RUN)))
      prescaler_nx = '0;
    else if ((state == ST_RUN) || (state == ST_EXPIRED))
      prescaler_nx = tick ? '0 : prescaler + PS_W'(1);

    blink_cnt_nx = blink_cnt;
    blink_nx     = blink;
    if ((state != ST_EXPIRED) || (state_nx != ST_EXPIRED)) begin
      blink_cnt_nx = '0;
      blink_nx     = 1'b0;
    end else if (tick) begin
      if (blink_cnt == BC_W'(BLINK_CS - 1)) begin
        blink_cnt_nx = '0;
        blink_nx     = ~blink;
      end else blink_cnt_nx = blink_cnt + BC_W'(1);
    end

    expired_nx = (state_nx == ST_EXPIRED);
    case (state_nx)
      ST_IDLE:           led_nx = '0;
      ST_RUN, ST_PAUSE:  led_nx = spot_led(time_nx);
      default:           led_nx = blink_nx ? 10'h3FF : 10'h000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      time_left <= '0;
      preset    <= '0;
      prescaler <= '0;
      blink_cnt <= '0;
      blink     <= 1'b0;
      expired   <= 1'b0;
      led       <= '0;
    end else begin
      state     <= state_nx;
      time_left <= time_nx;
      preset    <= preset_nx;
      prescaler <= prescaler_nx;
      blink_cnt <= blink_cnt_nx;
      blink     <= blink_nx;
      expired   <= expired_nx;
      led       <= led_nx;
    end
  end

endmodule

// File: tb/tb_countdown_timer_main.sv
// Scoreboard bench for countdown_timer_main with TICK_DIV=4, BLINK_CS=25:
// snapshots {time_left, led, expired} are queued at stimulus time and popped when sampled.
module tb_countdown_timer_main;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  keys = 4'hF;
  logic [18:0] time_left;
  logic        expired;
  logic [9:0]  led;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int run_start = 0;
  logic [29:0] exp_q[$];
  logic [29:0] expv, obs;

  countdown_timer_main #(.TICK_DIV(4), .MAX_TIME(359999), .BLINK_CS(25)) dut (
    .clk(clk), .rst(rst),
    .key3(keys[3]), .key2(keys[2]), .key1(keys[1]), .key0(keys[0]),
    .time_left(time_left), .expired(expired), .led(led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pushes the keys in mask; its effect has landed by the time this returns.
  task automatic press(input logic [3:0] mask);
    @(negedge clk); keys = keys & ~mask;
    repeat (4) @(negedge clk);
    keys = keys | mask;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  // Leaves us 1 time unit after the edge where RUN is entered; run_start is that edge.
  task automatic start_run();
    @(negedge clk); keys[3] = 1'b0;
    @(posedge clk); repeat (3) @(posedge clk); #1;
    keys[3] = 1'b1;
    run_start = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    exp_q.push_back({19'd0, 10'h000, 1'b0});
    repeat (3) @(negedge clk);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL reset_state: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_setting();
    exp_q.push_back({19'd12300, 10'h000, 1'b0});
    repeat (2) press(4'b0100);
    repeat (3) press(4'b0010);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL setting_sum: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    exp_q.push_back({19'd0, 10'h000, 1'b0});
    press(4'b0001);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL setting_clear: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
  endtask

  task automatic test_saturation();
    exp_q.push_back({19'd359999, 10'h000, 1'b0});
    repeat (61) press(4'b0100);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL sat_minutes: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    exp_q.push_back({19'd359999, 10'h000, 1'b0});
    press(4'b0010);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL sat_seconds: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    press(4'b0001);
  endtask

  task automatic test_countdown();
    repeat (3) press(4'b0010);
    exp_q.push_back({19'd300, 10'h008, 1'b0});
    start_run();
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL cd_run_entry: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    exp_q.push_back({19'd200, 10'h004, 1'b0});
    wait_to(run_start + 400);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL cd_at_400: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    exp_q.push_back({19'd1, 10'h001, 1'b0});
    wait_to(run_start + 1199);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL cd_last_cs: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    exp_q.push_back({19'd0, 10'h000, 1'b1});
    wait_to(run_start + 1200);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL cd_expired: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    exp_q.push_back({19'd0, 10'h000, 1'b1});
    exp_q.push_back({19'd0, 10'h3FF, 1'b1});
    exp_q.push_back({19'd0, 10'h000, 1'b1});
    wait_to(run_start + 1299);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL blink_before: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    wait_to(run_start + 1300);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL blink_on: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    wait_to(run_start + 1400);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL blink_off: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    exp_q.push_back({19'd300, 10'h000, 1'b0});
    press(4'b0010);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL cd_acknowledge: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
  endtask

  task automatic test_pause();
    int p;
    start_run();
    wait_to(run_start + 197);
    keys[3] = 1'b0;
    exp_q.push_back({19'd250, 10'h004, 1'b0});
    wait_to(run_start + 201);
    keys[3] = 1'b1;
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL pause_entry: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    p = cyc;
    exp_q.push_back({19'd250, 10'h004, 1'b0});
    wait_to(p + 1000);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL pause_hold: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    p = cyc;
    keys[3] = 1'b0;
    wait_to(p + 4);
    keys[3] = 1'b1;
    exp_q.push_back({19'd250, 10'h004, 1'b0});
    exp_q.push_back({19'd249, 10'h004, 1'b0});
    wait_to(p + 6);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL resume_wait: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    wait_to(p + 7);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL resume_dec: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    exp_q.push_back({19'd300, 10'h000, 1'b0});
    press(4'b0001);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL run_abort: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    press(4'b0001);
    exp_q.push_back({19'd0, 10'h000, 1'b0});
    press(4'b1000);
    repeat (20) @(negedge clk);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL start_at_zero: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    exp_q.push_back({19'd100, 10'h000, 1'b0});
    press(4'b0010);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL still_idle: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    press(4'b0001);
  endtask

  task automatic test_simultaneous();
    repeat (3) press(4'b0010);
    start_run();
    wait_to(run_start + 40);
    exp_q.push_back({19'd300, 10'h000, 1'b0});
    press(4'b1001);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL key0_key3_same: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    press(4'b0001);
    press(4'b0010);
    start_run();
    wait_to(run_start + 396);
    keys[3] = 1'b0;
    exp_q.push_back({19'd0, 10'h000, 1'b1});
    exp_q.push_back({19'd0, 10'h000, 1'b1});
    wait_to(run_start + 400);
    keys[3] = 1'b1;
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL key3_on_last_tick: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    wait_to(run_start + 420);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL expired_holds: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    exp_q.push_back({19'd100, 10'h000, 1'b0});
    press(4'b0001);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL expired_ack_key0: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
  endtask

  task automatic test_reset_midop();
    repeat (2) press(4'b0100);
    start_run();
    wait_to(run_start + 100);
    #3 rst = 1'b1;
    exp_q.push_back({19'd0, 10'h000, 1'b0});
    #1;
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL rst_mid_run: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    @(negedge clk); rst = 1'b0;
    exp_q.push_back({19'd100, 10'h000, 1'b0});
    press(4'b0010);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL idle_after_rst_run: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    start_run();
    exp_q.push_back({19'd0, 10'h3FF, 1'b1});
    wait_to(run_start + 550);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL pre_rst_expired: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    #3 rst = 1'b1;
    exp_q.push_back({19'd0, 10'h000, 1'b0});
    #1;
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL rst_mid_expired: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
    @(negedge clk); rst = 1'b0;
    press(4'b1000);
    exp_q.push_back({19'd100, 10'h000, 1'b0});
    press(4'b0010);
    obs = {time_left, led, expired}; expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL idle_after_rst_exp: got %0d/%h/%b expected %0d/%h/%b", obs[29:11], obs[10:1], obs[0], expv[29:11], expv[10:1], expv[0]); end
  endtask

  initial begin
    test_reset();
    test_setting();
    test_saturation();
    test_countdown();
    test_pause();
    test_simultaneous();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
